// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
//
// Multi-cycle shift-add multiply controller for the 8-bit single-cycle CPU.
// It takes over the MUL opcode from the ALU path. It holds the PC through
// BUSYWAIT while it iterates, then writes the low product byte to the
// register file in a single writeback cycle.
//
// Timing per MUL: 1 accept edge (IDLE) + WIDTH RUN edges + 1 WRITE edge.
// BUSYWAIT is high for WIDTH+1 cycles and drops in the WRITE cycle, so the
// PC advances on the same edge at which reg_file captures the product.
//
// Ports:
//   CLK              system clock, rising-edge
//   RESET            synchronous, active-low reset
//   START            high while the current instruction is MUL
//   OPERAND_A        multiplicand (REGOUT1)
//   OPERAND_B        multiplier   (REGOUT2)
//   DEST_REG         destination register address
//   BUSYWAIT         stall request to the PC update logic
//   MUL_WRITEENABLE  register-file write enable for the product
//   MUL_WRITEREG     register-file write address
//   MUL_RESULT       low WIDTH bits of the unsigned product
//   OVERFLOW         high if any upper-half product bit is set
//   DONE             one-cycle pulse in the writeback cycle
// -----------------------------------------------------------------------------
module mul_sequencer #(
  parameter int WIDTH   = 8,
  parameter int REGADDR = 3,
  parameter int CNTW    = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [WIDTH-1:0]   OPERAND_A,
  input  logic [WIDTH-1:0]   OPERAND_B,
  input  logic [REGADDR-1:0] DEST_REG,
  output logic               BUSYWAIT,
  output logic               MUL_WRITEENABLE,
  output logic [REGADDR-1:0] MUL_WRITEREG,
  output logic [WIDTH-1:0]   MUL_RESULT,
  output logic               OVERFLOW,
  output logic               DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WIDTH - 1);

  state_e               state_q,  state_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNTW-1:0]      cnt_q,    cnt_d;
  logic [REGADDR-1:0]   dest_q,   dest_d;
  // Last written product, so MUL_RESULT/OVERFLOW hold between operations.
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ovf_q,    ovf_d;

  // Next-state and datapath logic.
  // NOTE: every signal gets a default at the top of the block; without it a
  // path through the case that skips an assignment would infer a latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          // Operands are latched here; later register-file writes to the
          // source registers cannot disturb the running multiply.
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, OPERAND_A};
          mplier_d = OPERAND_B;
          dest_d   = DEST_REG;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNTW'(1);
        // Always WIDTH iterations: constant latency, no early exit on zero.
        if (cnt_q == LAST_ITER) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        result_d = acc_q[WIDTH-1:0];
        ovf_d    = |acc_q[2*WIDTH-1:WIDTH];
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      dest_q   <= dest_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Output decode. BUSYWAIT must follow START combinationally in IDLE so the
  // PC does not advance on the accepting edge. Everything is forced low while
  // RESET is asserted, which also suppresses a write on an aborted WRITE.
  always_comb begin
    BUSYWAIT        = 1'b0;
    MUL_WRITEENABLE = 1'b0;
    MUL_WRITEREG    = '0;
    MUL_RESULT      = '0;
    OVERFLOW        = 1'b0;
    DONE            = 1'b0;

    if (RESET) begin
      MUL_WRITEREG = dest_q;
      MUL_RESULT   = result_q;
      OVERFLOW     = ovf_q;

      case (state_q)
        IDLE: BUSYWAIT = START;
        RUN:  BUSYWAIT = 1'b1;
        WRITE: begin
          MUL_WRITEENABLE = 1'b1;
          DONE            = 1'b1;
          MUL_RESULT      = acc_q[WIDTH-1:0];
          OVERFLOW        = |acc_q[2*WIDTH-1:WIDTH];
        end
        default: BUSYWAIT = 1'b0;
      endcase
    end
  end

endmodule
